// File: rtl/riscv_pkg.sv
// riscv_pkg: opcode, FSM state and instruction-field definitions shared by the decode stage.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package riscv_pkg;

    // RV32I major opcodes (instr[6:0])
    localparam logic [6:0] OP     = 7'b0110011;
    localparam logic [6:0] OP_IMM = 7'b0010011;
    localparam logic [6:0] LOAD   = 7'b0000011;
    localparam logic [6:0] STORE  = 7'b0100011;
    localparam logic [6:0] BRANCH = 7'b1100011;
    localparam logic [6:0] JAL    = 7'b1101111;
    localparam logic [6:0] JALR   = 7'b1100111;
    localparam logic [6:0] LUI    = 7'b0110111;
    localparam logic [6:0] AUIPC  = 7'b0010111;

    // Decode-stage sequencing; one instruction in flight at a time.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CHECK = 2'd1,
        READ  = 2'd2,
        OUT   = 2'd3
    } state_t;

    // Instruction field positions
    localparam int OPCODE_LSB  = 0;
    localparam int OPCODE_W    = 7;
    localparam int RD_LSB      = 7;
    localparam int FUNCT3_LSB  = 12;
    localparam int FUNCT3_W    = 3;
    localparam int RS1_LSB     = 15;
    localparam int RS2_LSB     = 20;
    localparam int FUNCT7_LSB  = 25;
    localparam int FUNCT7_W    = 7;
    localparam int REG_FIELD_W = 5;

    // rs1 is read by everything except the upper-immediate forms and JAL.
    function automatic logic uses_rs1(input logic [6:0] opc);
        return !((opc == LUI) || (opc == AUIPC) || (opc == JAL));
    endfunction

    // rs2 is read only by register-register ALU ops, stores and branches.
    function automatic logic uses_rs2(input logic [6:0] opc);
        return (opc == OP) || (opc == STORE) || (opc == BRANCH);
    endfunction

    // Stores and branches carry immediate bits where rd would sit.
    function automatic logic writes_rd(input logic [6:0] opc, input logic [4:0] rd);
        return (rd != 5'd0) && (opc != STORE) && (opc != BRANCH);
    endfunction

endpackage

// File: rtl/riscv_imm_gen.sv
// riscv_imm_gen: RV32I immediate extraction and sign extension by instruction format.
// Latency: purely combinational.
// Backpressure: none (no handshake).
// Ports: instr (32-bit instruction word) in, imm (XLEN sign-extended immediate) out.
module riscv_imm_gen
    import riscv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     instr,
    output logic [XLEN-1:0] imm
);

    logic [31:0] imm32;

    always_comb begin
        imm32 = '0;
        case (instr[OPCODE_LSB +: OPCODE_W])
            OP_IMM, LOAD, JALR: imm32 = {{20{instr[31]}}, instr[31:20]};
            STORE:              imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            BRANCH:             imm32 = {{19{instr[31]}}, instr[31], instr[7],
                                         instr[30:25], instr[11:8], 1'b0};
            LUI, AUIPC:         imm32 = {instr[31:12], 12'b0};
            JAL:                imm32 = {{11{instr[31]}}, instr[31], instr[19:12],
                                         instr[20], instr[30:21], 1'b0};
            // R-type and anything unrecognised carry no immediate
            default:            imm32 = '0;
        endcase
    end

    // Widening cast of a signed value replicates the sign bit up to XLEN.
    assign imm = XLEN'(signed'(imm32));

endmodule

// File: rtl/riscv_decode_stage.sv
// riscv_decode_stage: RV32I decode/operand fetch with RAW scoreboard in front of the register file.
// Latency: accept in IDLE -> out_valid three cycles later without hazard; +1 cycle per stall cycle.
// Backpressure: in_ready only in IDLE; bundle held stable while out_valid && !out_ready.
// Ports: clk/rst (sync, active-high), flush; fetch in_valid/in_ready/in_instr/in_pc;
//        register file rf_rs1/rf_rs2/rf_read/rf_rd1/rf_rd2; writeback wb_valid/wb_rd/wb_data;
//        execute out_valid/out_ready and the decoded bundle out_pc..out_op2.
// Optional: define DECODE_WB_BYPASS_EN to resolve a hazard in the same cycle writeback retires it.
module riscv_decode_stage
    import riscv_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int NAME_BITS = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [31:0]          in_instr,
    input  logic [XLEN-1:0]      in_pc,
    output logic [NAME_BITS-1:0] rf_rs1,
    output logic [NAME_BITS-1:0] rf_rs2,
    output logic                 rf_read,
    input  logic [XLEN-1:0]      rf_rd1,
    input  logic [XLEN-1:0]      rf_rd2,
    input  logic                 wb_valid,
    input  logic [NAME_BITS-1:0] wb_rd,
    input  logic [XLEN-1:0]      wb_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [XLEN-1:0]      out_pc,
    output logic [6:0]           out_opcode,
    output logic [2:0]           out_funct3,
    output logic [6:0]           out_funct7,
    output logic [NAME_BITS-1:0] out_rd,
    output logic                 out_wen,
    output logic [XLEN-1:0]      out_imm,
    output logic [XLEN-1:0]      out_op1,
    output logic [XLEN-1:0]      out_op2
);

    localparam int NREGS = 1 << NAME_BITS;

    state_t           state;
    logic [31:0]      instr_q;
    logic [XLEN-1:0]  pc_q;
    logic [NREGS-1:0] sb;
    logic [NREGS-1:0] sb_next;
    logic [XLEN-1:0]  imm;
    logic [6:0]       opc;
    logic             use1;
    logic             use2;
    logic             pend1;
    logic             pend2;
    logic             hazard;
    logic             handshake;
    logic             wen_dec;
    logic [XLEN-1:0]  src1;
    logic [XLEN-1:0]  src2;

    riscv_imm_gen #(.XLEN(XLEN)) u_imm_gen (
        .instr (instr_q),
        .imm   (imm)
    );

    assign opc     = instr_q[OPCODE_LSB +: OPCODE_W];
    assign use1    = uses_rs1(opc);
    assign use2    = uses_rs2(opc);
    assign wen_dec = writes_rd(opc, instr_q[RD_LSB +: REG_FIELD_W]);

    // rf_rs1/rf_rs2 hold the latched source names for the whole instruction.
    assign pend1 = use1 && (rf_rs1 != '0) && sb[rf_rs1];
    assign pend2 = use2 && (rf_rs2 != '0) && sb[rf_rs2];

`ifdef DECODE_WB_BYPASS_EN
    logic            byp_hit1;
    logic            byp_hit2;
    logic            byp_use1;
    logic            byp_use2;
    logic [XLEN-1:0] byp_val1;
    logic [XLEN-1:0] byp_val2;

    // A pending source retiring this very cycle is taken from wb_data; the
    // register file read issued on the same edge would still return the old value.
    assign byp_hit1 = pend1 && wb_valid && (wb_rd == rf_rs1);
    assign byp_hit2 = pend2 && wb_valid && (wb_rd == rf_rs2);
    assign hazard   = (pend1 && !byp_hit1) || (pend2 && !byp_hit2);
    assign src1     = byp_use1 ? byp_val1 : rf_rd1;
    assign src2     = byp_use2 ? byp_val2 : rf_rd2;

    always_ff @(posedge clk) begin
        if (rst) begin
            byp_use1 <= 1'b0;
            byp_use2 <= 1'b0;
            byp_val1 <= '0;
            byp_val2 <= '0;
        end else if ((state == CHECK) && !hazard && !flush) begin
            byp_use1 <= byp_hit1;
            byp_use2 <= byp_hit2;
            byp_val1 <= wb_data;
            byp_val2 <= wb_data;
        end
    end
`else
    logic unused_wb;
    assign unused_wb = ^wb_data;
    assign hazard    = pend1 || pend2;
    assign src1      = rf_rd1;
    assign src2      = rf_rd2;
`endif

    assign in_ready = (state == IDLE);

    // Strobe goes out in the CHECK cycle that clears, so the register file
    // answers during READ, where the data is captured.
    assign rf_read = (state == CHECK) && !hazard && !flush && !rst;

    assign handshake = (state == OUT) && out_valid && out_ready && !flush;

    // Clear then set: a retiring write and a new claim on the same register
    // in one cycle leaves the register claimed by the newer instruction.
    always_comb begin
        sb_next = sb;
        if (wb_valid) begin
            sb_next[wb_rd] = 1'b0;
        end
        if (handshake && out_wen) begin
            sb_next[out_rd] = 1'b1;
        end
        sb_next[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            sb         <= '0;
            instr_q    <= '0;
            pc_q       <= '0;
            rf_rs1     <= '0;
            rf_rs2     <= '0;
            out_valid  <= 1'b0;
            out_pc     <= '0;
            out_opcode <= '0;
            out_funct3 <= '0;
            out_funct7 <= '0;
            out_rd     <= '0;
            out_wen    <= 1'b0;
            out_imm    <= '0;
            out_op1    <= '0;
            out_op2    <= '0;
        end else begin
            sb <= sb_next;
            if (flush) begin
                state     <= IDLE;
                out_valid <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (in_valid) begin
                            instr_q <= in_instr;
                            pc_q    <= in_pc;
                            rf_rs1  <= NAME_BITS'(in_instr[RS1_LSB +: REG_FIELD_W]);
                            rf_rs2  <= NAME_BITS'(in_instr[RS2_LSB +: REG_FIELD_W]);
                            state   <= CHECK;
                        end
                    end
                    CHECK: begin
                        if (!hazard) begin
                            state <= READ;
                        end
                    end
                    READ: begin
                        out_pc     <= pc_q;
                        out_opcode <= opc;
                        out_funct3 <= instr_q[FUNCT3_LSB +: FUNCT3_W];
                        out_funct7 <= instr_q[FUNCT7_LSB +: FUNCT7_W];
                        out_rd     <= NAME_BITS'(instr_q[RD_LSB +: REG_FIELD_W]);
                        out_wen    <= wen_dec;
                        out_imm    <= imm;
                        out_op1    <= use1 ? src1 : '0;
                        out_op2    <= use2 ? src2 : '0;
                        out_valid  <= 1'b1;
                        state      <= OUT;
                    end
                    OUT: begin
                        if (out_ready) begin
                            out_valid <= 1'b0;
                            state     <= IDLE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_riscv_decode_stage.sv
// tb_riscv_decode_stage: directed bench for riscv_decode_stage with a register-file responder,
// a spec-level decode model and a per-cycle compare of the bundle and scoreboard.
module tb_riscv_decode_stage;

    localparam logic [6:0] M_OP     = 7'h33;
    localparam logic [6:0] M_OPIMM  = 7'h13;
    localparam logic [6:0] M_LOAD   = 7'h03;
    localparam logic [6:0] M_STORE  = 7'h23;
    localparam logic [6:0] M_BRANCH = 7'h63;
    localparam logic [6:0] M_JAL    = 7'h6F;
    localparam logic [6:0] M_JALR   = 7'h67;
    localparam logic [6:0] M_LUI    = 7'h37;
    localparam logic [6:0] M_AUIPC  = 7'h17;

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, in_ready;
    logic [31:0] in_instr, in_pc;
    logic [4:0]  rf_rs1, rf_rs2;
    logic        rf_read;
    logic [31:0] rf_rd1, rf_rd2;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        out_valid, out_ready;
    logic [31:0] out_pc;
    logic [6:0]  out_opcode;
    logic [2:0]  out_funct3;
    logic [6:0]  out_funct7;
    logic [4:0]  out_rd;
    logic        out_wen;
    logic [31:0] out_imm, out_op1, out_op2;

    int checks   = 0;
    int failures = 0;

    logic [31:0] regs [32];
    logic [31:0] sb_m;
    logic [31:0] cur_instr;
    logic [31:0] cur_pc;
    logic        exp_live;

    always #5 clk = ~clk;

    riscv_decode_stage dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
        .rf_rs1(rf_rs1), .rf_rs2(rf_rs2), .rf_read(rf_read), .rf_rd1(rf_rd1), .rf_rd2(rf_rd2),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
        .out_opcode(out_opcode), .out_funct3(out_funct3), .out_funct7(out_funct7),
        .out_rd(out_rd), .out_wen(out_wen), .out_imm(out_imm),
        .out_op1(out_op1), .out_op2(out_op2)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
        end
    endtask

    // ---------------- spec-level model ----------------
    function automatic int sext(input int val, input int bits);
        if (((val >> (bits - 1)) & 1) != 0) return val - (1 << bits);
        return val;
    endfunction

    function automatic logic [31:0] m_imm(input logic [31:0] ins);
        case (ins[6:0])
            M_OPIMM, M_LOAD, M_JALR:
                return 32'(sext(int'(ins >> 20), 12));
            M_STORE:
                return 32'(sext(int'(((ins >> 25) << 5) | ((ins >> 7) & 31)), 12));
            M_BRANCH:
                return 32'(sext(int'(((ins >> 31) << 12) | (((ins >> 7) & 1) << 11) |
                                     (((ins >> 25) & 63) << 5) | (((ins >> 8) & 15) << 1)), 13));
            M_LUI, M_AUIPC:
                return ins & 32'hFFFFF000;
            M_JAL:
                return 32'(sext(int'(((ins >> 31) << 20) | (((ins >> 12) & 255) << 12) |
                                     (((ins >> 20) & 1) << 11) | (((ins >> 21) & 1023) << 1)), 21));
            default:
                return 32'd0;
        endcase
    endfunction

    function automatic logic m_use1(input logic [31:0] ins);
        return !(ins[6:0] == M_LUI || ins[6:0] == M_AUIPC || ins[6:0] == M_JAL);
    endfunction

    function automatic logic m_use2(input logic [31:0] ins);
        return ins[6:0] == M_OP || ins[6:0] == M_STORE || ins[6:0] == M_BRANCH;
    endfunction

    function automatic logic m_wen(input logic [31:0] ins);
        return ins[11:7] != 5'd0 && ins[6:0] != M_STORE && ins[6:0] != M_BRANCH;
    endfunction

    // Register file responder: registered read one cycle after the strobe,
    // writes from writeback land at the same edge (read sees the old value).
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) regs[i] <= (i == 0) ? 32'd0 : 32'h100 * i + 32'h11;
            rf_rd1 <= 32'hDEADBEEF;
            rf_rd2 <= 32'hDEADBEEF;
        end else begin
            if (rf_read) begin
                rf_rd1 <= regs[rf_rs1];
                rf_rd2 <= regs[rf_rs2];
            end
            if (wb_valid && wb_rd != 5'd0) regs[wb_rd] <= wb_data;
        end
    end

    // Scoreboard model: retiring writes clear, accepted writers claim, x0 never pending.
    always @(posedge clk) begin : sb_model
        logic [31:0] nxt;
        nxt = sb_m;
        if (wb_valid) nxt[wb_rd] = 1'b0;
        if (out_valid && out_ready && !flush && exp_live && m_wen(cur_instr))
            nxt[cur_instr[11:7]] = 1'b1;
        nxt[0] = 1'b0;
        sb_m <= rst ? 32'd0 : nxt;
    end

    // Per-cycle compare of scoreboard and of the bundle whenever it is offered.
    always @(negedge clk) begin
        if (!rst) begin
            chk("scoreboard", dut.sb, sb_m);
            if (out_valid) begin
                if (!exp_live) begin
                    chk("out_valid_unexpected", 32'(out_valid), 32'd0);
                end else begin
                    chk("bundle_pc",     out_pc, cur_pc);
                    chk("bundle_opcode", 32'(out_opcode), 32'(cur_instr[6:0]));
                    chk("bundle_funct3", 32'(out_funct3), 32'(cur_instr[14:12]));
                    chk("bundle_funct7", 32'(out_funct7), 32'(cur_instr[31:25]));
                    chk("bundle_rd",     32'(out_rd), 32'(cur_instr[11:7]));
                    chk("bundle_wen",    32'(out_wen), 32'(m_wen(cur_instr)));
                    chk("bundle_imm",    out_imm, m_imm(cur_instr));
                    chk("bundle_op1",    out_op1, m_use1(cur_instr) ? regs[cur_instr[19:15]] : 32'd0);
                    chk("bundle_op2",    out_op2, m_use2(cur_instr) ? regs[cur_instr[24:20]] : 32'd0);
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic issue(input logic [31:0] ins, input logic [31:0] pc);
        @(posedge clk); #1;
        in_instr  = ins;
        in_pc     = pc;
        in_valid  = 1'b1;
        cur_instr = ins;
        cur_pc    = pc;
        exp_live  = 1'b1;
        @(negedge clk);
        chk("in_ready_at_issue", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_out(input int budget);
        int n;
        n = 0;
        @(negedge clk);
        while (!out_valid && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("out_valid_within_budget", 32'(out_valid), 32'd1);
    endtask

    // Called at a negedge with the bundle offered; completes at the next edge.
    task automatic handshake();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        exp_live  = 1'b0;
    endtask

    task automatic wb_pulse(input logic [4:0] rd, input logic [31:0] data);
        @(posedge clk); #1;
        wb_valid = 1'b1;
        wb_rd    = rd;
        wb_data  = data;
        @(posedge clk); #1;
        wb_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_instr = '0; in_pc = '0;
        wb_valid = 1'b0; wb_rd = '0; wb_data = '0; out_ready = 1'b0;
        exp_live = 1'b0; cur_instr = '0; cur_pc = '0; sb_m = '0;

        // Reset then idle
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("reset_in_ready", 32'(in_ready), 32'd1);
            chk("reset_rf_read", 32'(rf_read), 32'd0);
            chk("reset_out_valid", 32'(out_valid), 32'd0);
        end
        chk("reset_rf_rs1", 32'(rf_rs1), 32'd0);
        chk("reset_rf_rs2", 32'(rf_rs2), 32'd0);
        chk("reset_out_imm", out_imm, 32'd0);
        chk("reset_sb", dut.sb, 32'd0);

        // addi x1,x0,5: exact latency, operand fetch strobe in the CHECK cycle
        issue(32'h00500093, 32'h100);
        @(negedge clk);
        chk("addi_rf_read_c1", 32'(rf_read), 32'd1);
        chk("addi_out_valid_c1", 32'(out_valid), 32'd0);
        @(negedge clk);
        chk("addi_rf_read_c2", 32'(rf_read), 32'd0);
        chk("addi_out_valid_c2", 32'(out_valid), 32'd0);
        @(negedge clk);
        chk("addi_out_valid_c3", 32'(out_valid), 32'd1);
        chk("addi_imm_lit", out_imm, 32'd5);
        chk("addi_rd_lit", 32'(out_rd), 32'd1);
        chk("addi_op1_lit", out_op1, 32'd0);
        chk("addi_op2_unused_lit", out_op2, 32'd0);
        chk("addi_wen_lit", 32'(out_wen), 32'd1);
        chk("model_imm_addi", m_imm(32'h00500093), 32'd5);
        handshake();
        @(negedge clk);
        chk("addi_sb1_set", 32'(dut.sb[1]), 32'd1);

        // add x2,x1,x1: RAW stall until writeback of x1
        issue(32'h00108133, 32'h104);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("raw_stall_rf_read", 32'(rf_read), 32'd0);
            chk("raw_stall_out_valid", 32'(out_valid), 32'd0);
        end
        wb_pulse(5'd1, 32'd5);
        wait_out(8);
        chk("raw_op1_lit", out_op1, 32'd5);
        chk("raw_op2_lit", out_op2, 32'd5);
        handshake();

        // retire x2, then sw x2,8(x1) under backpressure
        wb_pulse(5'd2, 32'h22);
        issue(32'h0020A423, 32'h108);
        wait_out(8);
        for (int k = 0; k < 3; k++) begin
            chk("sw_in_ready_held", 32'(in_ready), 32'd0);
            chk("sw_imm_lit", out_imm, 32'd8);
            chk("sw_wen_lit", 32'(out_wen), 32'd0);
            @(negedge clk);
            chk("sw_out_valid_held", 32'(out_valid), 32'd1);
        end
        chk("sw_op2_lit", out_op2, 32'h22);
        handshake();

        // addi x3,x0,7: claim and retire of x3 in the same cycle
        issue(32'h00700193, 32'h10C);
        wait_out(8);
        wb_valid = 1'b1; wb_rd = 5'd3; wb_data = 32'h33;
        handshake();
        wb_valid = 1'b0;
        @(negedge clk);
        chk("setclr_sb3", 32'(dut.sb[3]), 32'd1);

        // jal x0,-4: negative J immediate, no destination
        issue(32'hFFDFF06F, 32'h110);
        wait_out(8);
        chk("jal_imm_lit", out_imm, 32'hFFFFFFFC);
        chk("jal_wen_lit", 32'(out_wen), 32'd0);
        chk("model_imm_jal", m_imm(32'hFFDFF06F), 32'hFFFFFFFC);
        handshake();

        // bne x0,x0,+16: B immediate
        issue(32'h00001863, 32'h114);
        wait_out(8);
        chk("bne_imm_lit", out_imm, 32'd16);
        chk("model_imm_bne", m_imm(32'h00001863), 32'd16);
        handshake();

        // lui x7,0x12345: source fields hold nonzero registers but are unused
        issue(32'h123453B7, 32'h118);
        wait_out(8);
        chk("lui_imm_lit", out_imm, 32'h12345000);
        chk("lui_op1_lit", out_op1, 32'd0);
        chk("lui_op2_lit", out_op2, 32'd0);
        handshake();

        // flush while the bundle is offered
        issue(32'h00100213, 32'h11C);
        wait_out(8);
        @(posedge clk); #1;
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        exp_live = 1'b0;
        @(negedge clk);
        chk("flush_out_valid", 32'(out_valid), 32'd0);
        chk("flush_in_ready", 32'(in_ready), 32'd1);
        chk("flush_sb_kept", dut.sb, 32'h88);

        // rst while stalled in CHECK on x3
        issue(32'h00318333, 32'h120);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("rstchk_rf_read", 32'(rf_read), 32'd0);
        end
        @(posedge clk); #1;
        rst = 1'b1;
        exp_live = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rstchk_in_ready", 32'(in_ready), 32'd1);
        chk("rstchk_out_valid", 32'(out_valid), 32'd0);
        chk("rstchk_sb", dut.sb, 32'd0);
        repeat (4) @(negedge clk);
        chk("rstchk_idle_out_valid", 32'(out_valid), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
